// File: rtl/collision_arbiter_pkg.sv
// Shared types, defaults and helpers for the collision arbiter slice.
package collision_pkg;

  typedef enum logic {
    MODE_IMMEDIATE = 1'b0,
    MODE_FRAME     = 1'b1
  } mode_t;

  localparam int DEF_N_SHOTS    = 3;
  localparam int DEF_N_ENEMIES  = 4;
  localparam int DEF_CNT_W      = 8;
  localparam int DEF_FRAME_MODE = 0;

  // Vectors wider than 32 bits are not supported by callers.
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) n = n + {31'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/collision_arbiter_if.sv
// Drawing-request inputs and collision/score outputs between painters and game logic.
interface collision_arbiter_if #(
  parameter int N_SHOTS   = 3,
  parameter int N_ENEMIES = 4,
  parameter int CNT_W     = 8
);
  logic                 startOfFrame;
  logic                 drawing_request_Ball;
  logic                 drawing_request_tower;
  logic                 drawing_request_enemy_HU;
  logic [N_ENEMIES-1:0] drawing_request_enemy;
  logic [N_SHOTS-1:0]   drawing_request_shot;
  logic                 score_clear;
  logic [N_SHOTS-1:0]   ShotBoxCollision;
  logic [N_SHOTS-1:0]   ShotEnemyCollision;
  logic [N_ENEMIES-1:0] EnemyHitCollision;
  logic                 TowerEnemyHUCollision;
  logic                 towerPlayerCollision;
  logic [CNT_W-1:0]     hit_count;

  modport master (
    output startOfFrame, drawing_request_Ball, drawing_request_tower,
           drawing_request_enemy_HU, drawing_request_enemy, drawing_request_shot, score_clear,
    input  ShotBoxCollision, ShotEnemyCollision, EnemyHitCollision,
           TowerEnemyHUCollision, towerPlayerCollision, hit_count
  );

  modport slave (
    input  startOfFrame, drawing_request_Ball, drawing_request_tower,
           drawing_request_enemy_HU, drawing_request_enemy, drawing_request_shot, score_clear,
    output ShotBoxCollision, ShotEnemyCollision, EnemyHitCollision,
           TowerEnemyHUCollision, towerPlayerCollision, hit_count
  );
endinterface

// File: rtl/collision_arbiter_hit_latch.sv
// Per-pair sticky "seen this frame" flag and one-cycle registered hit pulse.
module hit_latch
  import collision_pkg::*;
(
  input  logic  clk,
  input  logic  resetN,
  input  logic  startOfFrame,
  input  logic  hit,
  input  mode_t mode,
  output logic  pulse
);

  logic seen;

  // A hit coincident with startOfFrame belongs to the new frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      seen  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      seen <= startOfFrame ? hit : (seen | hit);
      if (mode == MODE_FRAME) pulse <= startOfFrame & seen;
      else                    pulse <= hit & (startOfFrame | ~seen);
    end
  end

endmodule

// File: rtl/collision_arbiter.sv
// Pixel-overlap collision detection with one pulse per pair per frame and a saturating hit score.
module collision_arbiter
  import collision_pkg::*;
#(
  parameter int N_SHOTS    = DEF_N_SHOTS,
  parameter int N_ENEMIES  = DEF_N_ENEMIES,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int FRAME_MODE = DEF_FRAME_MODE
) (
  input logic               clk,
  input logic               resetN,
  collision_arbiter_if.slave bus
);

  localparam mode_t       MODE    = (FRAME_MODE != 0) ? MODE_FRAME : MODE_IMMEDIATE;
  localparam int unsigned CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input int unsigned inc);
    int unsigned sum;
    sum = 32'(a) + inc;
    if (sum > CNT_MAX) return CNT_W'(CNT_MAX);
    return CNT_W'(sum);
  endfunction

  logic [N_SHOTS-1:0]   raw_shot_tower, raw_shot_enemy;
  logic [N_SHOTS-1:0]   shot_tower_pls, shot_enemy_pls;
  logic [N_ENEMIES-1:0] raw_enemy_hit, enemy_hit_pls;
  logic                 raw_hu_tower, raw_ball_tower;
  logic                 hu_tower_pls, ball_tower_pls;
  logic [CNT_W-1:0]     hit_count_q;

  assign raw_shot_tower = bus.drawing_request_shot & {N_SHOTS{bus.drawing_request_tower}};
  assign raw_shot_enemy = bus.drawing_request_shot & {N_SHOTS{|bus.drawing_request_enemy}};
  assign raw_enemy_hit  = bus.drawing_request_enemy & {N_ENEMIES{|bus.drawing_request_shot}};
  assign raw_hu_tower   = bus.drawing_request_enemy_HU & bus.drawing_request_tower;
  assign raw_ball_tower = bus.drawing_request_Ball & bus.drawing_request_tower;

  for (genvar i = 0; i < N_SHOTS; i++) begin : g_shot
    hit_latch u_shot_tower (
      .clk(clk), .resetN(resetN), .startOfFrame(bus.startOfFrame),
      .hit(raw_shot_tower[i]), .mode(MODE), .pulse(shot_tower_pls[i])
    );
    hit_latch u_shot_enemy (
      .clk(clk), .resetN(resetN), .startOfFrame(bus.startOfFrame),
      .hit(raw_shot_enemy[i]), .mode(MODE), .pulse(shot_enemy_pls[i])
    );
  end

  for (genvar j = 0; j < N_ENEMIES; j++) begin : g_enemy
    hit_latch u_enemy_hit (
      .clk(clk), .resetN(resetN), .startOfFrame(bus.startOfFrame),
      .hit(raw_enemy_hit[j]), .mode(MODE), .pulse(enemy_hit_pls[j])
    );
  end

  hit_latch u_hu_tower (
    .clk(clk), .resetN(resetN), .startOfFrame(bus.startOfFrame),
    .hit(raw_hu_tower), .mode(MODE), .pulse(hu_tower_pls)
  );

  hit_latch u_ball_tower (
    .clk(clk), .resetN(resetN), .startOfFrame(bus.startOfFrame),
    .hit(raw_ball_tower), .mode(MODE), .pulse(ball_tower_pls)
  );

  // Score counts the registered pulses, so it trails them by one clock; clear beats increment.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)              hit_count_q <= '0;
    else if (bus.score_clear) hit_count_q <= '0;
    else                      hit_count_q <= sat_add(hit_count_q, popcount(32'(shot_enemy_pls)));
  end

  assign bus.ShotBoxCollision      = shot_tower_pls;
  assign bus.ShotEnemyCollision    = shot_enemy_pls;
  assign bus.EnemyHitCollision     = enemy_hit_pls;
  assign bus.TowerEnemyHUCollision = hu_tower_pls;
  assign bus.towerPlayerCollision  = ball_tower_pls;
  assign bus.hit_count             = hit_count_q;

endmodule

// File: tb/tb_collision_arbiter.sv
// Directed bench: immediate, deferred and narrow-counter arbiters share one stimulus stream.
module tb_collision_arbiter;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  collision_arbiter_if #(.N_SHOTS(3), .N_ENEMIES(4), .CNT_W(8)) ifi ();
  collision_arbiter_if #(.N_SHOTS(3), .N_ENEMIES(4), .CNT_W(8)) ifd ();
  collision_arbiter_if #(.N_SHOTS(3), .N_ENEMIES(4), .CNT_W(2)) ifs ();

  collision_arbiter #(.N_SHOTS(3), .N_ENEMIES(4), .CNT_W(8), .FRAME_MODE(0))
    u_imm (.clk(clk), .resetN(resetN), .bus(ifi.slave));
  collision_arbiter #(.N_SHOTS(3), .N_ENEMIES(4), .CNT_W(8), .FRAME_MODE(1))
    u_def (.clk(clk), .resetN(resetN), .bus(ifd.slave));
  collision_arbiter #(.N_SHOTS(3), .N_ENEMIES(4), .CNT_W(2), .FRAME_MODE(0))
    u_sat (.clk(clk), .resetN(resetN), .bus(ifs.slave));

  assign ifd.startOfFrame             = ifi.startOfFrame;
  assign ifd.drawing_request_Ball     = ifi.drawing_request_Ball;
  assign ifd.drawing_request_tower    = ifi.drawing_request_tower;
  assign ifd.drawing_request_enemy_HU = ifi.drawing_request_enemy_HU;
  assign ifd.drawing_request_enemy    = ifi.drawing_request_enemy;
  assign ifd.drawing_request_shot     = ifi.drawing_request_shot;
  assign ifd.score_clear              = ifi.score_clear;
  assign ifs.startOfFrame             = ifi.startOfFrame;
  assign ifs.drawing_request_Ball     = ifi.drawing_request_Ball;
  assign ifs.drawing_request_tower    = ifi.drawing_request_tower;
  assign ifs.drawing_request_enemy_HU = ifi.drawing_request_enemy_HU;
  assign ifs.drawing_request_enemy    = ifi.drawing_request_enemy;
  assign ifs.drawing_request_shot     = ifi.drawing_request_shot;
  assign ifs.score_clear              = ifi.score_clear;

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifi.startOfFrame             = 1'b0;
    ifi.drawing_request_Ball     = 1'b0;
    ifi.drawing_request_tower    = 1'b0;
    ifi.drawing_request_enemy_HU = 1'b0;
    ifi.drawing_request_enemy    = 4'b0000;
    ifi.drawing_request_shot     = 3'b000;
    ifi.score_clear              = 1'b0;
  endtask

  task automatic sof_tick();
    idle();
    ifi.startOfFrame = 1'b1;
    tick();
    ifi.startOfFrame = 1'b0;
  endtask

  task automatic shot_enemy(input logic [2:0] s, input logic [3:0] e);
    idle();
    ifi.drawing_request_shot  = s;
    ifi.drawing_request_enemy = e;
  endtask

  initial begin
    idle();
    tick();
    tick();
    check_vec("rst_sbc",  32'(ifi.ShotBoxCollision), 32'd0);
    check_vec("rst_sec",  32'(ifi.ShotEnemyCollision), 32'd0);
    check_vec("rst_ehc",  32'(ifi.EnemyHitCollision), 32'd0);
    check_vec("rst_hu",   32'(ifi.TowerEnemyHUCollision), 32'd0);
    check_vec("rst_tp",   32'(ifi.towerPlayerCollision), 32'd0);
    check_vec("rst_cnt",  32'(ifi.hit_count), 32'd0);
    check_vec("rst_dtp",  32'(ifd.towerPlayerCollision), 32'd0);
    resetN = 1'b1;

    // Immediate single pair: shot1 on tower for 5 pixels.
    sof_tick();
    ifi.drawing_request_shot  = 3'b010;
    ifi.drawing_request_tower = 1'b1;
    tick();
    check_vec("imm_sbc_first", 32'(ifi.ShotBoxCollision), 32'b010);
    check_vec("def_sbc_hold",  32'(ifd.ShotBoxCollision), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_vec("imm_sbc_held", 32'(ifi.ShotBoxCollision), 32'd0);
    end
    idle();
    tick();
    check_vec("imm_sbc_after", 32'(ifi.ShotBoxCollision), 32'd0);

    // HU enemy and player against the tower.
    ifi.drawing_request_enemy_HU = 1'b1;
    ifi.drawing_request_Ball     = 1'b1;
    ifi.drawing_request_tower    = 1'b1;
    tick();
    check_vec("imm_hu", 32'(ifi.TowerEnemyHUCollision), 32'd1);
    check_vec("imm_tp", 32'(ifi.towerPlayerCollision), 32'd1);
    check_vec("def_tp_hold", 32'(ifd.towerPlayerCollision), 32'd0);
    idle();
    tick();
    check_vec("imm_tp_off", 32'(ifi.towerPlayerCollision), 32'd0);

    // Deferred report at the frame boundary.
    sof_tick();
    check_vec("def_sbc_sof", 32'(ifd.ShotBoxCollision), 32'b010);
    check_vec("def_tp_sof",  32'(ifd.towerPlayerCollision), 32'd1);
    check_vec("def_hu_sof",  32'(ifd.TowerEnemyHUCollision), 32'd1);
    check_vec("imm_sbc_sof", 32'(ifi.ShotBoxCollision), 32'd0);
    tick();
    check_vec("def_sbc_one", 32'(ifd.ShotBoxCollision), 32'd0);
    check_vec("def_tp_one",  32'(ifd.towerPlayerCollision), 32'd0);
    tick();
    tick();
    sof_tick();
    check_vec("def_empty_sbc", 32'(ifd.ShotBoxCollision), 32'd0);
    check_vec("def_empty_tp",  32'(ifd.towerPlayerCollision), 32'd0);

    // Multi-hit: shots 0 and 2 on enemy 3.
    shot_enemy(3'b101, 4'b1000);
    tick();
    check_vec("multi_sec", 32'(ifi.ShotEnemyCollision), 32'b101);
    check_vec("multi_ehc", 32'(ifi.EnemyHitCollision), 32'b1000);
    check_vec("multi_cnt_lag", 32'(ifi.hit_count), 32'd0);
    idle();
    tick();
    check_vec("multi_sec_off", 32'(ifi.ShotEnemyCollision), 32'd0);
    check_vec("multi_ehc_off", 32'(ifi.EnemyHitCollision), 32'd0);
    check_vec("multi_cnt", 32'(ifi.hit_count), 32'd2);
    check_vec("sat_cnt2",  32'(ifs.hit_count), 32'd2);

    // Saturation on the 2-bit counter.
    sof_tick();
    shot_enemy(3'b001, 4'b0001);
    tick();
    idle();
    tick();
    check_vec("sat_cnt3", 32'(ifs.hit_count), 32'd3);
    check_vec("imm_cnt3", 32'(ifi.hit_count), 32'd3);
    sof_tick();
    shot_enemy(3'b001, 4'b0001);
    tick();
    idle();
    tick();
    check_vec("sat_hold", 32'(ifs.hit_count), 32'd3);
    check_vec("imm_cnt4", 32'(ifi.hit_count), 32'd4);

    // Clear coinciding with an increment.
    sof_tick();
    shot_enemy(3'b001, 4'b0001);
    tick();
    check_vec("clr_pulse", 32'(ifi.ShotEnemyCollision), 32'b001);
    idle();
    ifi.score_clear = 1'b1;
    tick();
    ifi.score_clear = 1'b0;
    check_vec("clr_sat", 32'(ifs.hit_count), 32'd0);
    check_vec("clr_imm", 32'(ifi.hit_count), 32'd0);

    // Overlap in the startOfFrame cycle.
    idle();
    ifi.startOfFrame          = 1'b1;
    ifi.drawing_request_Ball  = 1'b1;
    ifi.drawing_request_tower = 1'b1;
    tick();
    check_vec("bnd_imm_tp", 32'(ifi.towerPlayerCollision), 32'd1);
    check_vec("bnd_def_tp", 32'(ifd.towerPlayerCollision), 32'd0);
    idle();
    tick();
    check_vec("bnd_imm_off", 32'(ifi.towerPlayerCollision), 32'd0);
    ifi.drawing_request_Ball  = 1'b1;
    ifi.drawing_request_tower = 1'b1;
    tick();
    check_vec("bnd_imm_second", 32'(ifi.towerPlayerCollision), 32'd0);
    idle();
    tick();
    sof_tick();
    check_vec("bnd_def_report", 32'(ifd.towerPlayerCollision), 32'd1);
    check_vec("bnd_imm_sof",    32'(ifi.towerPlayerCollision), 32'd0);

    // Reset mid-frame while a pulse is high.
    shot_enemy(3'b001, 4'b0001);
    tick();
    idle();
    tick();
    check_vec("mid_cnt", 32'(ifi.hit_count), 32'd1);
    ifi.drawing_request_shot  = 3'b010;
    ifi.drawing_request_tower = 1'b1;
    tick();
    check_vec("mid_sbc", 32'(ifi.ShotBoxCollision), 32'b010);
    idle();
    resetN = 1'b0;
    #2;
    check_vec("mid_rst_sbc", 32'(ifi.ShotBoxCollision), 32'd0);
    check_vec("mid_rst_cnt", 32'(ifi.hit_count), 32'd0);
    check_vec("mid_rst_sec", 32'(ifi.ShotEnemyCollision), 32'd0);
    tick();
    resetN = 1'b1;
    ifi.drawing_request_shot  = 3'b010;
    ifi.drawing_request_tower = 1'b1;
    tick();
    check_vec("post_rst_sbc", 32'(ifi.ShotBoxCollision), 32'b010);
    shot_enemy(3'b001, 4'b0001);
    tick();
    check_vec("post_rst_sec", 32'(ifi.ShotEnemyCollision), 32'b001);
    idle();
    tick();
    check_vec("post_rst_cnt", 32'(ifi.hit_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/collision_arbiter.md
# collision_arbiter

Parametrised collision arbiter between the per-object drawing-request painters and the game-logic blocks (shot, enemy, tower, player controllers). It detects pixel-overlap collisions for N shots and M enemies against the tower, the player and each other. It converts the per-pixel overlaps into at most one registered hit pulse per collision pair per frame. It also maintains a saturating shot-on-enemy hit counter for the score display.

## Interface
- N_SHOTS, 3: number of shot objects (≥1).
- N_ENEMIES, 4: number of enemy objects (≥1).
- CNT_W, 8: width of hit counter.
- FRAME_MODE, 0: 0 = immediate (pulse on first overlap pixel), 1 = deferred (pulse after frame end).
- clk  in  1  system clock (pixel clock domain).
- resetN  in  1  reset; one clock; reset is asynchronous and active-low.
- startOfFrame  in  1  one-cycle pulse at each frame start.
- drawing_request_Ball  in  1  player pixel active.
- drawing_request_tower  in  1  tower/wall pixel active.
- drawing_request_enemy_HU  in  1  hunting enemy pixel active.
- drawing_request_enemy  in  N_ENEMIES  per-enemy pixel active.
- drawing_request_shot  in  N_SHOTS  per-shot pixel active.
- score_clear  in  1  synchronous clear of hit_count.
- ShotBoxCollision  out  N_SHOTS  per-shot hit-tower pulse.
- ShotEnemyCollision  out  N_SHOTS  per-shot hit-any-enemy pulse.
- EnemyHitCollision  out  N_ENEMIES  per-enemy hit-by-any-shot pulse.
- TowerEnemyHUCollision  out  1  hunting enemy hit-tower pulse.
- towerPlayerCollision  out  1  player hit-tower pulse.
- hit_count  out  CNT_W  saturating count of shot-enemy hits.

## Operation
- Raw overlap, combinational, per pair:
  - shot i/tower = shot[i] & tower.
  - shot i/enemy = shot[i] & |(enemy & ~0). Enemy j is hit if enemy[j] & |shot.
  - HU/tower = HU & tower.
  - player/tower = Ball & tower.
- Each pair owns a sticky `seen` flag. The flag is cleared on startOfFrame and set on the first raw overlap in the frame.
- Immediate mode:
  - The output pulses for exactly one cycle on the cycle after the first raw overlap of the frame.
  - Further overlaps in the same frame produce no pulse.
- Deferred mode:
  - At startOfFrame, every pair whose `seen` flag is set pulses for exactly one cycle. All pulses align, one cycle after startOfFrame.
  - The flags then restart for the new frame.
- Overlap in the same cycle as startOfFrame belongs to the new frame in both modes. In immediate mode it fires a pulse; in deferred mode it sets the freshly cleared flag.
- hit_count adds popcount(ShotEnemyCollision) in every cycle that a pulse is present.
  - The counter saturates at 2^CNT_W−1; there is no wrap.
  - If score_clear and an increment occur in the same cycle, the clear wins and hit_count is 0.
- Reset (asserted at any point, including mid-frame) clears all flags, all pulse outputs and hit_count to 0. The first frame after reset starts with clear flags; no startOfFrame is needed before detection begins.

## Timing
- All outputs are registered. Latency from the overlap pixel to the pulse is 1 clk in immediate mode.
- In deferred mode, latency from startOfFrame to the pulse is 1 clk.
- Pulse width is exactly 1 clk.
- No pair produces more than 1 pulse per frame.
- hit_count updates on the cycle after the pulse, i.e. 2 clk after the overlap in immediate mode.
- Reset values: every output is 0.

## Structure
- Shared package `collision_pkg`:
  - `mode_t` enum (MODE_IMMEDIATE, MODE_FRAME).
  - default parameter constants.
  - `popcount` function.
- Sub-module `hit_latch`: one sticky flag plus pulse register, with inputs clk, resetN, startOfFrame, hit, mode. The top instantiates one per pair via generate: N_SHOTS×2 + N_ENEMIES + 2 instances.
- The top holds the raw-overlap logic, the generate loops and the counter.

## Test plan
- Immediate mode, single pair: shot[1] & tower held for 5 pixels starting at cycle 100 → ShotBoxCollision = 3'b010 for exactly cycle 101 only; no further pulse until the next startOfFrame.
- Deferred mode, two frames: the Ball overlaps the tower at cycle 50, then startOfFrame at cycle 200 → towerPlayerCollision pulses at cycle 201. A frame with no overlap → no pulse after the next startOfFrame.
- Multi-hit: shots 0 and 2 overlap enemy 3 in the same cycle.
  - ShotEnemyCollision = 3'b101 and EnemyHitCollision = 4'b1000 for one cycle.
  - hit_count goes from 0 to 2.
- Saturation and clear, CNT_W = 2:
  - hit_count sits at 3 and a further hit arrives → hit_count stays 3.
  - score_clear coincides with a hit → hit_count = 0.
- Boundary: overlap arrives in the same cycle as startOfFrame.
  - Immediate mode: pulse on the next cycle, and a second overlap later in that frame gives no pulse.
  - Deferred mode: the overlap is reported at the following frame boundary.
- Reset mid-frame: an immediate-mode pair is already pulsed when resetN is dropped and then released → all outputs are 0. A re-overlap in the same frame pulses again.
